debug_mem_dumper: RTL and testbench

DEBUG_MEM_DUMPER -- requirements
Module: debug_mem_dumper

---
 rtl/debug_mem_dumper_pkg.sv | 25 ++
 rtl/debug_mem_dumper.sv | 126 ++++++++++++
 tb/tb_debug_mem_dumper.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_mem_dumper_pkg.sv
// Shared debug package: memory geometry defaults and dumper state encoding,
// used by the memory stage, the debug unit and the memory dumper.
package debug_mem_dumper_pkg;

  // Byte-address width of the data memory and byte-within-word index width.
  localparam int unsigned DBG_MEM_ADDR_WIDTH = 8;
  localparam int unsigned DBG_BYTE_COUNT_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_ADDR = 3'd1,
    ST_LATCH    = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_TX  = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6
  } dump_state_e;

  // States in which the memory debug port is in use and a falling halt must
  // cancel the dump.
  function automatic logic dump_in_progress(input dump_state_e st);
    return (st != ST_IDLE) && (st != ST_DONE);
  endfunction

endpackage

// File: rtl/debug_mem_dumper.sv
// Dumps the whole data memory, word by word, MSB byte first, to a byte-wide
// serial transmitter while the pipeline is halted.
module debug_mem_dumper
  import debug_mem_dumper_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = DBG_MEM_ADDR_WIDTH,
  parameter int unsigned BYTE_COUNT_W   = DBG_BYTE_COUNT_W
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_halt,
  output logic [31:0] o_address_to_read,
  input  logic [31:0] i_mem_content,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_abort
);

  localparam int unsigned WORD_W = MEM_ADDR_WIDTH - 2;
  localparam logic [WORD_W-1:0]       WORD_LAST = '1;
  localparam logic [BYTE_COUNT_W-1:0] BYTE_LAST = '1;

  dump_state_e             state_q;
  logic [WORD_W-1:0]       word_q;
  logic [BYTE_COUNT_W-1:0] byte_q;
  logic [31:0]             shreg_q;
  logic [31:0]             addr_q;
  logic                    tx_start_q;
  logic                    done_q;
  logic                    abort_q;

  logic [WORD_W-1:0]       word_inc;
  logic [31:0]             addr_inc;

  // Next word index and its word-aligned, zero-extended byte address.
  always_comb begin
    word_inc = word_q + WORD_W'(1);
    addr_inc = '0;
    addr_inc[MEM_ADDR_WIDTH-1:2] = word_inc;
  end

  // Dump sequencer with inline byte serializer; all pulses are registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      addr_q     <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      // Losing halt invalidates the debug read port, so it outranks tx_done.
      if (dump_in_progress(state_q) && !i_halt) begin
        state_q <= ST_IDLE;
        addr_q  <= '0;
        abort_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_start && i_halt) begin
              word_q  <= '0;
              addr_q  <= '0;
              state_q <= ST_SET_ADDR;
            end
          end
          ST_SET_ADDR: state_q <= ST_LATCH;
          ST_LATCH: begin
            // tx_start is raised here so the pulse coincides with SEND.
            shreg_q    <= i_mem_content;
            byte_q     <= '0;
            tx_start_q <= 1'b1;
            state_q    <= ST_SEND;
          end
          ST_SEND: state_q <= ST_WAIT_TX;
          ST_WAIT_TX: begin
            if (i_tx_done) begin
              if (byte_q != BYTE_LAST) begin
                byte_q     <= byte_q + BYTE_COUNT_W'(1);
                shreg_q    <= {shreg_q[23:0], 8'h00};
                tx_start_q <= 1'b1;
                state_q    <= ST_SEND;
              end else begin
                state_q <= ST_NEXT;
              end
            end
          end
          ST_NEXT: begin
            if (word_q == WORD_LAST) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              word_q  <= word_inc;
              addr_q  <= addr_inc;
              state_q <= ST_SET_ADDR;
            end
          end
          ST_DONE: begin
            addr_q  <= '0;
            state_q <= ST_IDLE;
          end
          default: begin
            addr_q  <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_address_to_read = addr_q;
  assign o_tx_data         = shreg_q[31:24];
  assign o_tx_start        = tx_start_q;
  assign o_done            = done_q;
  assign o_abort           = abort_q;
  assign o_busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Bench for debug_mem_dumper with a 4-word memory and a 10-cycle transmitter.
module tb_debug_mem_dumper;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_halt;
  logic [31:0] o_address_to_read;
  logic [31:0] i_mem_content;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_done;
  logic        o_abort;

  logic        tx_done_model;
  logic        tx_done_spur;
  int          tx_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  int          cyc = 0;
  int          n_bytes = 0;
  int          n_done = 0;
  int          n_tx_total = 0;
  int          word_start = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  rec [16];
  bit          stim_done = 1'b0;

  always #5 i_clk = ~i_clk;

  debug_mem_dumper #(.MEM_ADDR_WIDTH(4), .BYTE_COUNT_W(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_halt(i_halt),
    .o_address_to_read(o_address_to_read), .i_mem_content(i_mem_content),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort)
  );

  // Memory: word k holds A0B0C000 + k.
  assign i_mem_content = 32'hA0B0C000 + (o_address_to_read >> 2);
  assign i_tx_done     = tx_done_model | tx_done_spur;

  // Transmitter: done pulse 10 cycles after each start.
  always @(negedge i_clk) begin
    tx_done_model = 1'b0;
    if (i_reset) tx_cnt = 0;
    else begin
      if (tx_cnt > 0) begin
        tx_cnt = tx_cnt - 1;
        if (tx_cnt == 0) tx_done_model = 1'b1;
      end
      if (o_tx_start) tx_cnt = 10;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = 32'hA0B0C000 + 32'(n / 4);
    return 8'((w >> (8 * (3 - (n % 4)))) & 32'hFF);
  endfunction

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget);
    for (int i = 0; i < budget && n_bytes < target; i++) begin
      @(negedge i_clk); #1;
    end
    if (n_bytes < target) check("wait_bytes_timeout", 32'(n_bytes), 32'(target));
  endtask

  task automatic wait_done(input int budget, input bit spam_start);
    for (int i = 0; i < budget && n_done == 0; i++) begin
      i_start = spam_start && (i % 7 == 3);
      @(negedge i_clk); #1;
    end
    i_start = 1'b0;
    if (n_done == 0) check("wait_done_timeout", 32'(n_done), 32'd1);
  endtask

  task automatic check_full_dump(input string tag);
    repeat (3) @(negedge i_clk);
    #1;
    check({tag, "_done_count"}, 32'(n_done), 32'd1);
    check({tag, "_byte_count"}, 32'(n_bytes), 32'd16);
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    check({tag, "_b0"},  32'(rec[0]),  32'hA0);
    check({tag, "_b3"},  32'(rec[3]),  32'h00);
    check({tag, "_b7"},  32'(rec[7]),  32'h01);
    check({tag, "_b13"}, 32'(rec[13]), 32'hB0);
    check({tag, "_b15"}, 32'(rec[15]), 32'h03);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},     o_address_to_read, 32'h0);
    check({tag, "_tx_data"},  32'(o_tx_data), 32'h0);
    check({tag, "_tx_start"}, 32'(o_tx_start), 32'h0);
    check({tag, "_done"},     32'(o_done), 32'h0);
    check({tag, "_abort"},    32'(o_abort), 32'h0);
    check({tag, "_busy"},     32'(o_busy), 32'h0);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_halt = 1'b1; tx_done_spur = 1'b0;
    fork
      // Monitor: checks the output stream every cycle against the byte model.
      begin
        while (!stim_done) begin
          @(negedge i_clk);
          cyc++;
          if (o_busy && !prev_busy) begin
            n_bytes = 0; n_done = 0; word_start = cyc;
            check("first_addr", o_address_to_read, 32'h0);
          end else if (o_busy && prev_busy && o_address_to_read != prev_addr) begin
            word_start = cyc;
            check("addr_step", o_address_to_read, 32'(n_bytes));
          end
          if (!o_busy) check("idle_addr", o_address_to_read, 32'h0);
          check("addr_aligned", 32'(o_address_to_read[1:0]), 32'h0);
          if (o_tx_start) begin
            n_tx_total++;
            check("tx_start_busy", 32'(o_busy), 32'd1);
            if (n_bytes >= 16) check("extra_byte", 32'(n_bytes), 32'd15);
            else begin
              check("byte", 32'(o_tx_data), 32'(exp_byte(n_bytes)));
              check("byte_addr", o_address_to_read, 32'((n_bytes / 4) * 4));
              if (n_bytes % 4 == 0) check("latency", 32'(cyc - word_start), 32'd2);
              rec[n_bytes] = o_tx_data;
            end
            n_bytes++;
          end
          if (o_done) begin
            n_done++;
            check("done_after_last", 32'(n_bytes), 32'd16);
          end
          prev_busy = o_busy;
          prev_addr = o_address_to_read;
        end
      end
      // Stimulus
      begin
        repeat (3) @(negedge i_clk);
        #1;
        check_all_zero("reset");
        i_reset = 1'b0;
        @(negedge i_clk);

        // Start without halt is ignored.
        i_halt = 1'b0;
        pulse_start();
        begin
          int t0;
          t0 = n_tx_total;
          for (int i = 0; i < 20; i++) begin
            @(negedge i_clk); #1;
            check("nohalt_busy", 32'(o_busy), 32'd0);
            check("nohalt_abort", 32'(o_abort), 32'd0);
          end
          check("nohalt_tx", 32'(n_tx_total), 32'(t0));
        end

        // Full dump.
        i_halt = 1'b1;
        @(negedge i_clk);
        pulse_start();
        wait_done(400, 1'b0);
        check_full_dump("dump1");

        // Spurious tx_done in idle, repeated start while busy.
        repeat (3) begin
          tx_done_spur = 1'b1; @(negedge i_clk);
          tx_done_spur = 1'b0; @(negedge i_clk);
          #1 check("spur_busy", 32'(o_busy), 32'd0);
        end
        pulse_start();
        wait_done(400, 1'b1);
        check_full_dump("dump2");

        // Abort after the 5th byte.
        pulse_start();
        wait_bytes(5, 200);
        i_halt = 1'b0;
        @(negedge i_clk); #1;
        check("abort_pulse", 32'(o_abort), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        begin
          int t0;
          t0 = n_tx_total;
          @(negedge i_clk); #1;
          check("abort_one_cycle", 32'(o_abort), 32'd0);
          repeat (30) @(negedge i_clk);
          #1;
          check("abort_no_tx", 32'(n_tx_total), 32'(t0));
          check("abort_no_done", 32'(n_done), 32'd0);
          check("abort_bytes", 32'(n_bytes), 32'd5);
        end
        i_halt = 1'b1;
        @(negedge i_clk);

        // Reset during word 2 WAIT_TX, then restart from address 0.
        pulse_start();
        wait_bytes(9, 300);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk); #1;
        check_all_zero("midreset");
        i_reset = 1'b0;
        @(negedge i_clk);
        pulse_start();
        wait_done(400, 1'b0);
        check_full_dump("dump3");

        stim_done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
